multicycle_control: RTL

Multi-cycle main controller for the MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back. Per state, it drives the datapath mux selects, the register-file and memory strobes, and the 2-bit ALUop consumed by the ALU control decoder. It supports add, sub, mul, srl (R-type), lw, sw and lui. Multi-cycle `mul` execution is handled by an internal stall counter.

---
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main controller sequencing fetch, decode,
// execute, memory access and write-back, with a stall counter for mul.
module multicycle_control #(
   parameter int MUL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ALUop,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic [3:0] state
);
   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] EXEC_R   = 4'd2;
   localparam logic [3:0] EXEC_MUL = 4'd3;
   localparam logic [3:0] EXEC_SRL = 4'd4;
   localparam logic [3:0] EXEC_LUI = 4'd5;
   localparam logic [3:0] ADDR     = 4'd6;
   localparam logic [3:0] MEM_RD   = 4'd7;
   localparam logic [3:0] MEM_WR   = 4'd8;
   localparam logic [3:0] WB_ALU   = 4'd9;
   localparam logic [3:0] WB_MEM   = 4'd10;
   localparam logic [3:0] IDLE     = 4'd14;
   localparam logic [3:0] ILLEGAL  = 4'd15;

   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_R    = 3'd1;
   localparam logic [2:0] C_MUL  = 3'd2;
   localparam logic [2:0] C_SRL  = 3'd3;
   localparam logic [2:0] C_LW   = 3'd4;
   localparam logic [2:0] C_SW   = 3'd5;
   localparam logic [2:0] C_LUI  = 3'd6;

   logic [3:0] state_next;
   logic [2:0] cls, cls_next;
   logic [7:0] cnt;

   always_comb begin
      cls_next = C_NONE;
      if (opcode == 6'b000000)
         cls_next = (funct == 6'b100000 || funct == 6'b100010) ? C_R :
                    (funct == 6'b011000) ? C_MUL :
                    (funct == 6'b000010) ? C_SRL : C_NONE;
      else
         cls_next = (opcode == 6'b100011) ? C_LW :
                    (opcode == 6'b101011) ? C_SW :
                    (opcode == 6'b001111) ? C_LUI : C_NONE;
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:     state_next = FETCH;
         FETCH:    state_next = mem_ready ? DECODE : FETCH;
         DECODE:   state_next = (cls_next == C_R)   ? EXEC_R :
                                (cls_next == C_MUL) ? EXEC_MUL :
                                (cls_next == C_SRL) ? EXEC_SRL :
                                (cls_next == C_LUI) ? EXEC_LUI :
                                (cls_next == C_LW || cls_next == C_SW) ? ADDR : ILLEGAL;
         EXEC_R,
         EXEC_SRL,
         EXEC_LUI: state_next = WB_ALU;
         EXEC_MUL: state_next = (cnt == 8'd0) ? WB_ALU : EXEC_MUL;
         ADDR:     state_next = (cls == C_SW) ? MEM_WR : MEM_RD;
         MEM_RD:   state_next = mem_ready ? WB_MEM : MEM_RD;
         MEM_WR:   state_next = mem_ready ? FETCH : MEM_WR;
         WB_ALU,
         WB_MEM:   state_next = FETCH;
         ILLEGAL:  state_next = ILLEGAL;
         default:  state_next = IDLE;
      endcase
   end

   // the counter is preloaded in DECODE so EXEC_MUL lasts exactly MUL_CYCLES cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cls   <= C_NONE;
         cnt   <= 8'd0;
      end else begin
         state <= state_next;
         if (state == DECODE) begin
            cls <= cls_next;
            cnt <= 8'(MUL_CYCLES - 1);
         end else if (state == EXEC_MUL && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ALUop      = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
         end
         EXEC_R, EXEC_MUL: begin
            alu_src_a = 1'b1;
            ALUop     = 2'b10;
         end
         EXEC_SRL: begin
            alu_src_a = 1'b1;
            ALUop     = 2'b01;
         end
         EXEC_LUI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ALUop     = 2'b11;
         end
         ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         WB_ALU: begin
            reg_write = 1'b1;
            reg_dst   = (cls != C_LUI);
         end
         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end
endmodule
